// File: rtl/axi_4_lite_mst_pkg.sv
// axi_4_lite_mst_pkg: bus widths, AXI response codes, master state encodings and a saturating-increment helper.
package axi_4_lite_mst_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  localparam logic [2:0] MST_IDLE = 3'd0;
  localparam logic [2:0] MST_WR = 3'd1;
  localparam logic [2:0] MST_WR_RESP = 3'd2;
  localparam logic [2:0] MST_RD_ADDR = 3'd3;
  localparam logic [2:0] MST_RD_DATA = 3'd4;
  localparam logic [2:0] MST_RSP = 3'd5;
  function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic en);
    return (en && c != 16'hFFFF) ? c + 16'd1 : c;
  endfunction
endpackage

// File: rtl/axi_4_lite_mst_if.sv
// axi_4_lite_mst_if: command/response port plus the five AXI4-Lite channels driven by the master.
interface axi_4_lite_mst_if;
  import axi_4_lite_mst_pkg::*;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_wstrb;
  logic rsp_valid, rsp_ready, rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0] awprot;
  logic wvalid, wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic bvalid, bready;
  logic [1:0] bresp;
  logic arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0] arprot;
  logic rvalid, rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0] rresp;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
           awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
           awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
           awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
           awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready
  );
endinterface

// File: rtl/axi_4_lite_mst_stats.sv
// axi_4_lite_mst_stats: saturating write, read and error-response counters.
module axi_4_lite_mst_stats
  import axi_4_lite_mst_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic inc_wr,
  input  logic inc_rd,
  input  logic inc_err,
  output logic [15:0] wr_cnt,
  output logic [15:0] rd_cnt,
  output logic [15:0] err_cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      err_cnt <= '0;
    end else begin
      wr_cnt <= sat_inc(wr_cnt, inc_wr);
      rd_cnt <= sat_inc(rd_cnt, inc_rd);
      err_cnt <= sat_inc(err_cnt, inc_err);
    end
endmodule

// File: rtl/axi_4_lite_mst.sv
// axi_4_lite_mst: single-outstanding AXI4-Lite master bridging a valid/ready command/response port.
// Define AXI_4_LITE_MST_STATS_EN to add saturating transaction/error counters.
module axi_4_lite_mst
  import axi_4_lite_mst_pkg::*;
(
  input  logic m_axi_aclk,
  input  logic m_axi_aresetn,
`ifdef AXI_4_LITE_MST_STATS_EN
  output logic [15:0] stat_wr_cnt,
  output logic [15:0] stat_rd_cnt,
  output logic [15:0] stat_err_cnt,
`endif
  axi_4_lite_mst_if.master bus
);
  logic [2:0] state;
  logic b_got, b_cap, r_cap, aw_done, w_done;
  logic [1:0] cap_resp;
  assign b_cap = bus.bvalid && bus.bready;
  assign r_cap = bus.rvalid && bus.rready && (state == MST_RD_DATA || bus.arready);
  assign cap_resp = b_cap ? bus.bresp : bus.rresp;
  assign aw_done = !bus.awvalid || bus.awready;
  assign w_done = !bus.wvalid || bus.wready;
  assign bus.awprot = 3'b000;
  assign bus.arprot = 3'b000;
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn)
    if (!m_axi_aresetn) begin
      state <= MST_IDLE;
      b_got <= 1'b0;
      bus.cmd_ready <= 1'b1;
      bus.awvalid <= 1'b0;
      bus.wvalid <= 1'b0;
      bus.bready <= 1'b0;
      bus.arvalid <= 1'b0;
      bus.rready <= 1'b0;
      bus.awaddr <= '0;
      bus.araddr <= '0;
      bus.wdata <= '0;
      bus.wstrb <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_write <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_resp <= OKAY;
    end else begin
      if (b_cap || r_cap) begin
        bus.rsp_resp <= cap_resp;
        bus.rsp_write <= b_cap;
        bus.rsp_rdata <= b_cap ? '0 : bus.rdata;
      end
      if (b_cap) begin
        bus.bready <= 1'b0;
        b_got <= 1'b1;
      end
      if (r_cap) bus.rready <= 1'b0;
      case (state)
        MST_IDLE: if (bus.cmd_valid) begin
          bus.cmd_ready <= 1'b0;
          b_got <= 1'b0;
          if (bus.cmd_write) begin
            bus.awaddr <= bus.cmd_addr;
            bus.wdata <= bus.cmd_wdata;
            bus.wstrb <= bus.cmd_wstrb;
            bus.awvalid <= 1'b1;
            bus.wvalid <= 1'b1;
            bus.bready <= 1'b1;
            state <= MST_WR;
          end else begin
            bus.araddr <= bus.cmd_addr;
            bus.arvalid <= 1'b1;
            bus.rready <= 1'b1;
            state <= MST_RD_ADDR;
          end
        end
        MST_WR: begin
          if (bus.awready) bus.awvalid <= 1'b0;
          if (bus.wready) bus.wvalid <= 1'b0;
          // an early B (tolerated) is held in b_got until both AW and W complete
          if (aw_done && w_done) begin
            state <= (b_cap || b_got) ? MST_RSP : MST_WR_RESP;
            bus.rsp_valid <= b_cap || b_got;
          end
        end
        MST_WR_RESP: if (b_cap) begin
          state <= MST_RSP;
          bus.rsp_valid <= 1'b1;
        end
        MST_RD_ADDR: if (bus.arready) begin
          bus.arvalid <= 1'b0;
          state <= r_cap ? MST_RSP : MST_RD_DATA;
          bus.rsp_valid <= r_cap;
        end
        MST_RD_DATA: if (r_cap) begin
          state <= MST_RSP;
          bus.rsp_valid <= 1'b1;
        end
        MST_RSP: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          bus.cmd_ready <= 1'b1;
          state <= MST_IDLE;
        end
        default: state <= MST_IDLE;
      endcase
    end
`ifdef AXI_4_LITE_MST_STATS_EN
  axi_4_lite_mst_stats u_stats (
    .clk     (m_axi_aclk),
    .rst_n   (m_axi_aresetn),
    .inc_wr  (b_cap),
    .inc_rd  (r_cap),
    .inc_err ((b_cap || r_cap) && cap_resp != OKAY),
    .wr_cnt  (stat_wr_cnt),
    .rd_cnt  (stat_rd_cnt),
    .err_cnt (stat_err_cnt)
  );
`endif
endmodule

// File: tb/tb_axi_4_lite_mst.sv
// tb_axi_4_lite_mst: drives the master against a behavioural register slave; expected responses go through a scoreboard queue.
module tb_axi_4_lite_mst;
  import axi_4_lite_mst_pkg::*;
  typedef struct packed {
    logic        write;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  exp_t e;
  logic obs_write;
  logic [31:0] obs_rdata;
  logic [1:0] obs_resp;
  int aw_lat, w_lat;
  logic [1:0] b_resp_cfg, r_resp_cfg;
  logic aw_got, w_got;
  int aw_wait, w_wait, b_cnt, ar_cnt;
  logic [31:0] aw_q, w_q;
  logic [3:0] ws_q;
  logic [31:0] mem [16];
  axi_4_lite_mst_if bus();
`ifdef AXI_4_LITE_MST_STATS_EN
  logic [15:0] stat_wr_cnt, stat_rd_cnt, stat_err_cnt;
`endif
  axi_4_lite_mst dut (
    .m_axi_aclk    (clk),
    .m_axi_aresetn (rst_n),
`ifdef AXI_4_LITE_MST_STATS_EN
    .stat_wr_cnt   (stat_wr_cnt),
    .stat_rd_cnt   (stat_rd_cnt),
    .stat_err_cnt  (stat_err_cnt),
`endif
    .bus           (bus)
  );
  always #5 clk = ~clk;
  // behavioural slave: programmable AW/W ready delay, registered B/R, byte-strobed memory
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.awready <= 1'b0;
      bus.wready <= 1'b0;
      bus.bvalid <= 1'b0;
      bus.bresp <= OKAY;
      bus.arready <= 1'b0;
      bus.rvalid <= 1'b0;
      bus.rdata <= '0;
      bus.rresp <= OKAY;
      aw_got <= 1'b0;
      w_got <= 1'b0;
      aw_wait <= 0;
      w_wait <= 0;
      aw_q <= '0;
      w_q <= '0;
      ws_q <= '0;
      b_cnt <= 0;
      ar_cnt <= 0;
    end else begin
      if (bus.awvalid && bus.awready) begin
        bus.awready <= 1'b0;
        aw_got <= 1'b1;
        aw_q <= bus.awaddr;
        aw_wait <= 0;
      end else if (bus.awvalid && !aw_got) begin
        if (aw_wait >= aw_lat) bus.awready <= 1'b1;
        else aw_wait <= aw_wait + 1;
      end
      if (bus.wvalid && bus.wready) begin
        bus.wready <= 1'b0;
        w_got <= 1'b1;
        w_q <= bus.wdata;
        ws_q <= bus.wstrb;
        w_wait <= 0;
      end else if (bus.wvalid && !w_got) begin
        if (w_wait >= w_lat) bus.wready <= 1'b1;
        else w_wait <= w_wait + 1;
      end
      if (bus.bvalid && bus.bready) begin
        bus.bvalid <= 1'b0;
        b_cnt <= b_cnt + 1;
      end else if (aw_got && w_got && !bus.bvalid) begin
        for (int i = 0; i < 4; i++)
          if (ws_q[i]) mem[aw_q[5:2]][8*i +: 8] <= w_q[8*i +: 8];
        bus.bvalid <= 1'b1;
        bus.bresp <= b_resp_cfg;
        aw_got <= 1'b0;
        w_got <= 1'b0;
      end
      if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
      if (bus.arvalid && bus.arready) begin
        bus.arready <= 1'b0;
        bus.rvalid <= 1'b1;
        bus.rdata <= mem[bus.araddr[5:2]];
        bus.rresp <= r_resp_cfg;
        ar_cnt <= ar_cnt + 1;
      end else if (bus.arvalid) bus.arready <= 1'b1;
    end

  task automatic issue_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr = a;
    bus.cmd_wdata = d;
    bus.cmd_wstrb = s;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL cmd_accept: cmd_ready=%b after 200 cycles, want 1", bus.cmd_ready);
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!bus.rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL rsp_timeout: rsp_valid=%b after 200 cycles, want 1", bus.rsp_valid);
    end
    obs_write = bus.rsp_write;
    obs_rdata = bus.rsp_rdata;
    obs_resp = bus.rsp_resp;
  endtask

  task automatic ack_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready);
    end
    checks++;
    if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, bus.rsp_valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_handshakes: got %b want 000000",
               {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, bus.rsp_valid});
    end
    checks++;
    if ({bus.awaddr, bus.araddr, bus.wdata, bus.wstrb, bus.rsp_rdata} !== 132'd0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", {bus.awaddr, bus.araddr, bus.wdata, bus.wstrb, bus.rsp_rdata});
    end
    checks++;
    if ({bus.rsp_write, bus.rsp_resp} !== {1'b0, OKAY}) begin
      errors++;
      $display("FAIL reset_rsp: got %b want 000", {bus.rsp_write, bus.rsp_resp});
    end
    checks++;
    if ({bus.awprot, bus.arprot} !== 6'b0) begin
      errors++;
      $display("FAIL reset_prot: got %b want 000000", {bus.awprot, bus.arprot});
    end
`ifdef AXI_4_LITE_MST_STATS_EN
    checks++;
    if ({stat_wr_cnt, stat_rd_cnt, stat_err_cnt} !== 48'd0) begin
      errors++;
      $display("FAIL reset_stats: got %h want 0", {stat_wr_cnt, stat_rd_cnt, stat_err_cnt});
    end
`endif
  endtask

  task automatic test_write_read();
    sb.push_back(exp_t'{1'b1, 32'h0, OKAY});
    issue_cmd(1'b1, 32'h04, 32'hDEADBEEF, 4'hF);
    wait_rsp();
    ack_rsp();
    e = sb.pop_front();
    checks++;
    if ({obs_write, obs_rdata, obs_resp} !== e) begin
      errors++;
      $display("FAIL wr_rsp: got %h want %h", {obs_write, obs_rdata, obs_resp}, e);
    end
    checks++;
    if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL after_ack: rsp_valid,cmd_ready got %b want 01", {bus.rsp_valid, bus.cmd_ready});
    end
    sb.push_back(exp_t'{1'b0, 32'hDEADBEEF, OKAY});
    issue_cmd(1'b0, 32'h04, 32'h0, 4'h0);
    wait_rsp();
    ack_rsp();
    e = sb.pop_front();
    checks++;
    if ({obs_write, obs_rdata, obs_resp} !== e) begin
      errors++;
      $display("FAIL rd_rsp: got %h want %h", {obs_write, obs_rdata, obs_resp}, e);
    end
  endtask

  task automatic test_strobe();
    sb.push_back(exp_t'{1'b1, 32'h0, OKAY});
    issue_cmd(1'b1, 32'h08, 32'h11223344, 4'hF);
    wait_rsp();
    ack_rsp();
    sb.push_back(exp_t'{1'b1, 32'h0, OKAY});
    issue_cmd(1'b1, 32'h08, 32'h000000AA, 4'b0001);
    wait_rsp();
    ack_rsp();
    sb.push_back(exp_t'{1'b0, 32'h112233AA, OKAY});
    issue_cmd(1'b0, 32'h08, 32'h0, 4'h0);
    wait_rsp();
    ack_rsp();
    for (int k = 0; k < 3; k++) begin
      e = sb.pop_front();
      if (k == 2) begin
        checks++;
        if ({obs_write, obs_rdata, obs_resp} !== e) begin
          errors++;
          $display("FAIL strobe_readback: got %h want %h", {obs_write, obs_rdata, obs_resp}, e);
        end
      end
    end
  endtask

  task automatic test_aw_before_w();
    int n, b0;
    logic saw_alone, held_bad, extra_rsp;
    aw_lat = 0;
    w_lat = 3;
    n = 0;
    saw_alone = 1'b0;
    held_bad = 1'b0;
    extra_rsp = 1'b0;
    b0 = b_cnt;
    sb.push_back(exp_t'{1'b1, 32'h0, OKAY});
    issue_cmd(1'b1, 32'h0C, 32'h55AA55AA, 4'hF);
    while (!bus.rsp_valid && n < 200) begin
      if (!bus.awvalid && bus.wvalid) saw_alone = 1'b1;
      if (bus.wvalid && bus.wdata !== 32'h55AA55AA) held_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    wait_rsp();
    ack_rsp();
    e = sb.pop_front();
    checks++;
    if ({obs_write, obs_rdata, obs_resp} !== e) begin
      errors++;
      $display("FAIL split_rsp: got %h want %h", {obs_write, obs_rdata, obs_resp}, e);
    end
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid) extra_rsp = 1'b1;
    end
    checks++;
    if (saw_alone !== 1'b1) begin
      errors++;
      $display("FAIL aw_drops_alone: got %b want 1", saw_alone);
    end
    checks++;
    if (held_bad !== 1'b0) begin
      errors++;
      $display("FAIL wdata_held: unstable=%b want 0", held_bad);
    end
    checks++;
    if ({b_cnt - b0, extra_rsp} !== {32'd1, 1'b0}) begin
      errors++;
      $display("FAIL one_response: b_handshakes=%0d extra_rsp=%b want 1 and 0", b_cnt - b0, extra_rsp);
    end
    w_lat = 0;
    sb.push_back(exp_t'{1'b0, 32'h55AA55AA, OKAY});
    issue_cmd(1'b0, 32'h0C, 32'h0, 4'h0);
    wait_rsp();
    ack_rsp();
    e = sb.pop_front();
    checks++;
    if ({obs_write, obs_rdata, obs_resp} !== e) begin
      errors++;
      $display("FAIL split_readback: got %h want %h", {obs_write, obs_rdata, obs_resp}, e);
    end
  endtask

  task automatic test_rsp_hold();
    int a0;
    sb.push_back(exp_t'{1'b0, 32'hDEADBEEF, OKAY});
    issue_cmd(1'b0, 32'h04, 32'h0, 4'h0);
    wait_rsp();
    a0 = ar_cnt;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr = 32'h08;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid, bus.cmd_ready, bus.arvalid} !== 3'b100) begin
        errors++;
        $display("FAIL hold_ctrl[%0d]: rsp_valid,cmd_ready,arvalid got %b want 100", k,
                 {bus.rsp_valid, bus.cmd_ready, bus.arvalid});
      end
      checks++;
      if (bus.rsp_rdata !== obs_rdata) begin
        errors++;
        $display("FAIL hold_rdata[%0d]: got %h want %h", k, bus.rsp_rdata, obs_rdata);
      end
    end
    bus.cmd_valid = 1'b0;
    ack_rsp();
    e = sb.pop_front();
    checks++;
    if ({obs_write, obs_rdata, obs_resp} !== e) begin
      errors++;
      $display("FAIL hold_rsp: got %h want %h", {obs_write, obs_rdata, obs_resp}, e);
    end
    checks++;
    if (ar_cnt !== a0) begin
      errors++;
      $display("FAIL hold_no_ar: ar handshakes got %0d want %0d", ar_cnt, a0);
    end
  endtask

  task automatic test_error();
`ifdef AXI_4_LITE_MST_STATS_EN
    logic [15:0] wr0, rd0, er0;
    wr0 = stat_wr_cnt;
    rd0 = stat_rd_cnt;
    er0 = stat_err_cnt;
`endif
    r_resp_cfg = SLVERR;
    sb.push_back(exp_t'{1'b0, 32'h112233AA, SLVERR});
    issue_cmd(1'b0, 32'h08, 32'h0, 4'h0);
    wait_rsp();
    ack_rsp();
    r_resp_cfg = OKAY;
    e = sb.pop_front();
    checks++;
    if ({obs_write, obs_rdata, obs_resp} !== e) begin
      errors++;
      $display("FAIL slverr_rsp: got %h want %h", {obs_write, obs_rdata, obs_resp}, e);
    end
`ifdef AXI_4_LITE_MST_STATS_EN
    checks++;
    if ({stat_rd_cnt, stat_err_cnt} !== {rd0 + 16'd1, er0 + 16'd1}) begin
      errors++;
      $display("FAIL stats_rd_err: rd,err got %0d,%0d want %0d,%0d", stat_rd_cnt, stat_err_cnt, rd0 + 16'd1, er0 + 16'd1);
    end
`endif
    b_resp_cfg = DECERR;
    sb.push_back(exp_t'{1'b1, 32'h0, DECERR});
    issue_cmd(1'b1, 32'h14, 32'h00000001, 4'hF);
    wait_rsp();
    ack_rsp();
    b_resp_cfg = OKAY;
    e = sb.pop_front();
    checks++;
    if ({obs_write, obs_rdata, obs_resp} !== e) begin
      errors++;
      $display("FAIL decerr_rsp: got %h want %h", {obs_write, obs_rdata, obs_resp}, e);
    end
`ifdef AXI_4_LITE_MST_STATS_EN
    checks++;
    if ({stat_wr_cnt, stat_err_cnt} !== {wr0 + 16'd1, er0 + 16'd2}) begin
      errors++;
      $display("FAIL stats_wr_err: wr,err got %0d,%0d want %0d,%0d", stat_wr_cnt, stat_err_cnt, wr0 + 16'd1, er0 + 16'd2);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic saw_rsp;
    saw_rsp = 1'b0;
    aw_lat = 8;
    w_lat = 8;
    issue_cmd(1'b1, 32'h10, 32'h99999999, 4'hF);
    @(negedge clk);
    checks++;
    if ({bus.awvalid, bus.wvalid} !== 2'b11) begin
      errors++;
      $display("FAIL mid_pending: awvalid,wvalid got %b want 11", {bus.awvalid, bus.wvalid});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, bus.rsp_valid} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset: valids/readys got %b want 000000",
               {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, bus.rsp_valid});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    aw_lat = 0;
    w_lat = 0;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready: got %b want 1", bus.cmd_ready);
    end
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid) saw_rsp = 1'b1;
    end
    checks++;
    if (saw_rsp !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_no_rsp: got %b want 0", saw_rsp);
    end
    sb.push_back(exp_t'{1'b0, 32'hDEADBEEF, OKAY});
    issue_cmd(1'b0, 32'h04, 32'h0, 4'h0);
    wait_rsp();
    ack_rsp();
    e = sb.pop_front();
    checks++;
    if ({obs_write, obs_rdata, obs_resp} !== e) begin
      errors++;
      $display("FAIL post_reset_read: got %h want %h", {obs_write, obs_rdata, obs_resp}, e);
    end
  endtask

  initial begin
    aw_lat = 0;
    w_lat = 0;
    b_resp_cfg = OKAY;
    r_resp_cfg = OKAY;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_wdata = '0;
    bus.cmd_wstrb = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_strobe();
    test_aw_before_w();
    test_rsp_hold();
    test_error();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi_4_lite_mst.md
Name: axi_4_lite_mst

Overview:
Single-outstanding AXI4-Lite master that converts a simple valid/ready command/response interface into AXI4-Lite read and write transactions. It sits directly upstream of axi_4_lite_slv and drives its five channels. It gives test benches and on-chip controllers (UART bridge, sequencer) register access without hand-toggling AXI signals.

Parameters:
ADDR_W, `C_AXI_ADDR_WIDTH, AXI address width.
DATA_W, `C_AXI_DATA_WIDTH, AXI data width (multiple of 8).
STRB_W, `C_AXI_STROBE_WIDTH, DATA_W/8.

Ports:
M_AXI_ACLK  in  1  single clock; all logic on the rising edge.
M_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
CMD_VALID  in  1  command present.
CMD_READY  out  1  command accepted when CMD_VALID && CMD_READY.
CMD_WRITE  in  1  1 = write, 0 = read.
CMD_ADDR  in  ADDR_W  byte address.
CMD_WDATA  in  DATA_W  write data.
CMD_WSTRB  in  STRB_W  write byte strobes.
RSP_VALID  out  1  response present.
RSP_READY  in  1  response consumed.
RSP_WRITE  out  1  echo of the command type.
RSP_RDATA  out  DATA_W  read data; 0 for writes.
RSP_RESP  out  2  BRESP or RRESP as captured.
M_AXI_AWVALID/AWREADY/AWADDR/AWPROT  out/in/out/out  1/1/ADDR_W/3  write address channel.
M_AXI_WVALID/WREADY/WDATA/WSTRB  out/in/out/out  1/1/DATA_W/STRB_W  write data channel.
M_AXI_BVALID/BREADY/BRESP  in/out/in  1/1/2  write response channel.
M_AXI_ARVALID/ARREADY/ARADDR/ARPROT  out/in/out/out  1/1/ADDR_W/3  read address channel.
M_AXI_RVALID/RREADY/RDATA/RRESP  in/out/in/in  1/1/DATA_W/2  read data channel.

Behaviour:
- Reset (async, active-low): state IDLE; CMD_READY=1; all *VALID and *READY outputs =0; AWADDR, ARADDR, WDATA, WSTRB, RSP_RDATA =0; RSP_RESP=`OKAY; RSP_WRITE=0; AWPROT=ARPROT=3'b000 (constant). Reset mid-transaction drops everything; no response is issued.
- All AXI and RSP outputs are registered.
- States: IDLE, WR (AW and W outstanding), WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE: CMD_READY=1. On the handshake, latch address/data/strobe. Write -> WR with AWVALID=WVALID=BREADY=1. Read -> RD_ADDR with ARVALID=1 and RREADY=1. CMD_READY=0 from the next cycle.
- WR: AWVALID and WVALID are tracked independently. Each drops the cycle after its own handshake. Address and data stay stable while VALID=1. When both are done (same cycle or different cycles), go to WR_RESP. BREADY stays 1 throughout WR and WR_RESP, because the downstream slave accepts W only while BREADY=1.
- WR_RESP: on BVALID&&BREADY, capture BRESP, set RSP_WRITE=1, RSP_RDATA=0, BREADY=0, and go to RSP. A BVALID that arrives during WR before AW/W complete is also accepted; that is a protocol tolerance, and RSP is still entered only once both AW and W are done.
- RD_ADDR: hold ARVALID until ARREADY, then ARVALID=0 and go to RD_DATA. RVALID in the same cycle as ARREADY is captured immediately; go straight to RSP.
- RD_DATA: on RVALID&&RREADY, capture RDATA/RRESP, set RSP_WRITE=0, RREADY=0, and go to RSP.
- RSP: RSP_VALID=1 and RSP fields stable until RSP_READY. On the handshake: RSP_VALID=0, CMD_READY=1, go to IDLE. Minimum back-to-back command spacing is 1 idle cycle after the response handshake.
- A VALID output never deasserts before its handshake. SLVERR/DECERR responses pass through unchanged. There is no timeout.
- Minimum latency, command handshake to RSP_VALID: write 3 cycles, read 3 cycles, with a zero-wait slave.

Optional Feature:
AXI_4_LITE_MST_STATS_EN:
- Defined: adds outputs STAT_WR_CNT[15:0], STAT_RD_CNT[15:0], STAT_ERR_CNT[15:0].
  - STAT_WR_CNT increments on each B handshake; STAT_RD_CNT on each R handshake.
  - STAT_ERR_CNT increments when the captured resp != `OKAY.
  - All counters saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared include axi_4_lite_configuration.vh holds:
  - width constants;
  - `OKAY/`SLVERR/`DECERR;
  - the new master state encodings (MST_IDLE..MST_RSP, 3-bit).
- Sub-module axi_4_lite_mst_stats holds the three saturating counters. It is instantiated only under AXI_4_LITE_MST_STATS_EN.

Test Plan:
- With axi_4_lite_slv downstream: write 0xDEADBEEF to 0x04 with WSTRB=4'hF, then read 0x04 -> RSP_RDATA=0xDEADBEEF, RSP_RESP=2'b00, RSP_WRITE=0.
- Write 0x000000AA to 0x08 with WSTRB=4'b0001 over a preloaded 0x11223344 -> readback 0x112233AA.
- Behavioural slave raising AWREADY 3 cycles before WREADY -> AWVALID drops alone; WVALID and WDATA are held until WREADY; exactly one response.
- Hold RSP_READY=0 for 5 cycles after a read -> RSP_VALID stays 1, RSP_RDATA is stable, CMD_READY=0, and no new AR is issued.
- Behavioural slave returning RRESP=2'b10 -> RSP_RESP=2'b10. With STATS_EN: STAT_ERR_CNT=1, STAT_RD_CNT=1.
- Assert M_AXI_ARESETN low in WR while AWVALID=1 -> all VALIDs 0 immediately (asynchronous), CMD_READY=1 after release, no RSP_VALID.
